fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of decode, the register file and the control unit. It owns the program counter and issues word requests to instruction memory over a request/grant/response handshake. Returned instructions are buffered in a small prefetch FIFO and presented to decode with a valid/ready handshake. Decode/execute redirects the PC on a taken branch or jump, which flushes all fetched and in-flight instructions.

Parameters:
DATA_WIDTH, 32, instruction/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, prefetch FIFO entries; also the cap on fifo_count + outstanding; legal range 2..8

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  DATA_WIDTH  word-aligned fetch address (current fetch PC)
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid; exactly one cycle after the matching grant, in order
imem_rdata_i  in  DATA_WIDTH  response instruction word
redirect_i  in  1  PC redirect (taken branch/jump)
redirect_pc_i  in  DATA_WIDTH  redirect target
instr_valid_o  out  1  FIFO head valid
instr_o  out  DATA_WIDTH  FIFO head instruction
instr_pc_o  out  DATA_WIDTH  PC of FIFO head
instr_ready_i  in  1  decode consumes head
fetch_fault_o  out  1  misaligned redirect detected (sticky)

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard_cnt=0; state=RUN; fault=0. All outputs 0 during reset except imem_addr_o, which equals RESET_PC.
- pop = instr_valid_o & instr_ready_i.
- imem_req_o = (state==RUN) & !redirect_i & (fifo_count + outstanding - pop < FIFO_DEPTH). This is combinational, and the only combinational input path is redirect_i/instr_ready_i.
- Grant (imem_req_o & imem_gnt_i): fetch_pc += 4 (mod 2^32, wraps silently), outstanding += 1. The PC for each grant is pushed into an internal in-order PC tag queue of depth FIFO_DEPTH.
- Response: if discard_cnt>0, drop the word, discard_cnt -= 1, outstanding -= 1. Otherwise, write {rdata, tagged PC} to the FIFO and outstanding -= 1. Grant and response in the same cycle net to zero.
- FIFO write at the response edge; instr_valid_o rises the next cycle. Latency from grant to instr_valid_o is 2 cycles. Sustained throughput is 1 instr/cycle with FIFO_DEPTH>=2 and ready held high.
- Push and pop in the same cycle on a full FIFO are legal. The credit rule guarantees a push never occurs on a full FIFO without a pop; treat overflow as an assertion failure.
- Head outputs (instr_o, instr_pc_o) stay stable while instr_valid_o & !instr_ready_i.
- Redirect (highest priority): FIFO cleared; PC tag queue cleared; fetch_pc = {redirect_pc_i[31:2],2'b00}; discard_cnt = outstanding - (imem_rvalid_i ? 1 : 0). Any response arriving in the redirect cycle is dropped. No grant is possible in the redirect cycle. Pop is ignored in the redirect cycle. Fetching resumes the following cycle from the target.
- Redirect while discard_cnt>0 accumulates via the same formula; outstanding is never reset.
- FSM: RUN -> FAULT only with the optional feature enabled. FAULT -> RUN only via reset or a later aligned redirect.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: a redirect with redirect_pc_i[1:0]!=0 sets fetch_fault_o=1 (sticky), enters FAULT, clears the FIFO, and stops requesting. In-flight responses are still drained and discarded. A subsequent aligned redirect clears the fault and returns to RUN.
- Undefined: low two bits are silently masked, fetch_fault_o is tied 0, and the FAULT state does not exist.

Decomposition:
- Shared package rv32_pkg: DATA_WIDTH, RESET_PC default, the fetch FSM state enum (RUN, FAULT), and the packed struct fetch_entry_t {instr, pc}.
- Sub-module: sync_fifo (parameterised WIDTH and DEPTH, flush input, count output). It is instantiated for both the instruction FIFO and the PC tag queue.

Test Plan:
- Reset release, memory grants every cycle, ready=1: addresses 0,4,8,... issued back-to-back; first instr_valid_o 2 cycles after first grant; instr_pc_o 0,4,8 on consecutive cycles.
- ready=0 for 5 cycles: at most FIFO_DEPTH requests granted, then imem_req_o=0; the head holds PC 0 stable. Raising ready resumes 1/cycle with no loss or duplication.
- Redirect to 0x100 while one request is in flight: the in-flight word is dropped, the FIFO is empty next cycle, the next imem_addr_o is 0x100, and the next instr_pc_o is 0x100.
- Redirect in the same cycle as imem_rvalid_i with a pending response: that word is dropped, discard_cnt is correct, and no stale instruction appears.
- Grant withheld (gnt=0) for 3 cycles: imem_addr_o is held at 0x8, and the PC advances only on grant.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102: fetch_fault_o=1 and imem_req_o=0. A later redirect to 0x200 clears the fault and fetching restarts at 0x200. Without the macro, fetching continues from 0x100.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared fetch-stage types: default widths, fetch FSM states and the prefetch entry layout.
package rv32_pkg;

   localparam int                        DATA_WIDTH_DEF = 32;
   localparam logic [DATA_WIDTH_DEF-1:0] RESET_PC_DEF   = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [DATA_WIDTH_DEF-1:0] instr;
      logic [DATA_WIDTH_DEF-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage so it holds while not popped.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd;
   logic [AW-1:0]    r_wr;
   logic [CW-1:0]    r_count;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (push) begin
            r_mem[r_wr] <= push_data;
            r_wr        <= bump(r_wr);
         end
         if (pop) r_rd <= bump(r_rd);
         r_count <= r_count + CW'(push) - CW'(pop);
      end
   end

   assign head  = r_mem[r_rd];
   assign count = r_count;

   always_ff @(posedge clk) begin
      if (rst_n && !flush) assert (!(push && !pop && (r_count == CW'(DEPTH))));
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests, buffers returns for decode.
// Build option FETCH_ALIGN_CHECK_EN: misaligned redirect raises a sticky fault and halts fetching.
import rv32_pkg::*;

module fetch_unit #(
   parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEF,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] instr_pc_o,
   input  logic                  instr_ready_i,
   output logic                  fetch_fault_o
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_e          r_state;
   logic                  r_fault;
   logic [DATA_WIDTH-1:0] r_pc;
   logic [CW-1:0]         r_out;
   logic [CW-1:0]         r_disc;

   logic [CW-1:0]         w_fcount;
   logic [CW-1:0]         w_tcount;
   logic [DATA_WIDTH-1:0] w_tag_pc;
   fetch_entry_t          w_head;
   fetch_entry_t          w_push_entry;
   logic                  w_valid;
   logic                  w_pop;
   logic                  w_grant;
   logic                  w_keep;
   logic [CW:0]           w_inuse;

   assign w_valid = (w_fcount != '0);
   assign w_pop   = w_valid & instr_ready_i;

   // Credit: buffered + in-flight words, counting a slot freed by this cycle's pop.
   assign w_inuse    = {1'b0, w_fcount} + {1'b0, r_out} - {{CW{1'b0}}, w_pop};
   assign imem_req_o = rst_n & (r_state == RUN) & ~redirect_i &
                       (w_inuse < (CW + 1)'(FIFO_DEPTH));
   assign w_grant    = imem_req_o & imem_gnt_i;

   // Words belonging to pre-redirect requests are dropped, including any landing with the redirect.
   assign w_keep       = imem_rvalid_i & (r_disc == '0) & ~redirect_i;
   assign w_push_entry = '{instr: imem_rdata_i, pc: w_tag_pc};

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_instr_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_i),
      .push      (w_keep),
      .push_data (w_push_entry),
      .pop       (w_pop & ~redirect_i),
      .head      (w_head),
      .count     (w_fcount)
   );

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_i),
      .push      (w_grant),
      .push_data (r_pc),
      .pop       (w_keep),
      .head      (w_tag_pc),
      .count     (w_tcount)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc   <= RESET_PC;
         r_out  <= '0;
         r_disc <= '0;
      end else begin
         r_out <= r_out + CW'(w_grant) - CW'(imem_rvalid_i);
         if (redirect_i) begin
            r_pc   <= redirect_pc_i & ~DATA_WIDTH'(3);
            r_disc <= r_out - CW'(imem_rvalid_i);
         end else begin
            if (w_grant) r_pc <= r_pc + DATA_WIDTH'(4);
            if (imem_rvalid_i && (r_disc != '0)) r_disc <= r_disc - CW'(1);
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic w_misalign;
   assign w_misalign = (redirect_pc_i[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_fault <= 1'b0;
      end else if (redirect_i) begin
         r_state <= w_misalign ? FAULT : RUN;
         r_fault <= w_misalign;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_fault <= 1'b0;
      end else begin
         r_state <= RUN;
         r_fault <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst_n && w_keep) assert (w_tcount != '0);
   end

   assign imem_addr_o   = r_pc;
   assign instr_valid_o = w_valid;
   assign instr_o       = w_head.instr;
   assign instr_pc_o    = w_head.pc;
   assign fetch_fault_o = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;
   logic        fetch_fault_o;

   fetch_unit #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .fetch_fault_o (fetch_fault_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: program-order view of requests in flight and words waiting for decode.
   typedef struct { logic [31:0] pc; bit stale; } inf_t;
   logic [31:0] m_fifo[$];
   inf_t        m_inf[$];
   logic [31:0] m_fetch_pc;
   bit          m_fault;

   bit          exp_req, exp_valid, exp_fault;
   logic [31:0] exp_addr, exp_pc, exp_instr;
   logic        obs_req, obs_valid, obs_fault;
   logic [31:0] obs_addr, obs_pc, obs_instr;
   bit          obs_grant;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_init();
      m_fifo.delete();
      m_inf.delete();
      m_fetch_pc = 32'h0;
      m_fault    = 1'b0;
   endtask

   // One clock: sample at negedge, advance model at posedge, memory answers grants one cycle later.
   task automatic step();
      bit   pop, keep;
      inf_t e;
      @(negedge clk);
      obs_req   = imem_req_o;
      obs_addr  = imem_addr_o;
      obs_valid = instr_valid_o;
      obs_pc    = instr_pc_o;
      obs_instr = instr_o;
      obs_fault = fetch_fault_o;
      exp_valid = (m_fifo.size() != 0);
      exp_pc    = exp_valid ? m_fifo[0] : 32'h0;
      exp_instr = memf(exp_pc);
      exp_addr  = m_fetch_pc;
      exp_fault = m_fault;
      exp_req   = !m_fault && !redirect_i &&
                  ((m_fifo.size() + m_inf.size() - ((exp_valid && instr_ready_i) ? 1 : 0)) < DEPTH);
      obs_grant = obs_req && imem_gnt_i;
      pop       = exp_valid && instr_ready_i && !redirect_i;
      keep      = 1'b0;
      @(posedge clk);
      if (imem_rvalid_i && (m_inf.size() != 0)) begin
         e    = m_inf.pop_front();
         keep = !e.stale && !redirect_i;
      end
      if (redirect_i) begin
         m_fifo.delete();
         foreach (m_inf[i]) m_inf[i].stale = 1'b1;
         m_fetch_pc = redirect_pc_i & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
         m_fault = (redirect_pc_i[1:0] != 2'b00);
`endif
      end else begin
         if (pop) void'(m_fifo.pop_front());
         if (keep) m_fifo.push_back(e.pc);
         if (exp_req && imem_gnt_i) begin
            m_inf.push_back('{pc: m_fetch_pc, stale: 1'b0});
            m_fetch_pc += 32'd4;
         end
      end
      #1;
      imem_rvalid_i = obs_grant;
      imem_rdata_i  = obs_grant ? memf(obs_addr) : $urandom;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_gnt_i = 1'b0; instr_ready_i = 1'b0; redirect_i = 1'b0;
      redirect_pc_i = 32'h0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_init();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1; redirect_i = 1'b0;
      redirect_pc_i = 32'h0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b expected 0", imem_req_o); else n_pass++;
      n_chk++; if (imem_addr_o !== 32'h0) $display("FAIL reset_addr: got %h expected 00000000", imem_addr_o); else n_pass++;
      n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid_o); else n_pass++;
      n_chk++; if (instr_o !== 32'h0) $display("FAIL reset_instr: got %h expected 0", instr_o); else n_pass++;
      n_chk++; if (instr_pc_o !== 32'h0) $display("FAIL reset_pc: got %h expected 0", instr_pc_o); else n_pass++;
      n_chk++; if (fetch_fault_o !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fetch_fault_o); else n_pass++;
   endtask

   task automatic test_stream();
      int first_g = -1, first_v = -1;
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (first_g < 0 && obs_grant) first_g = i;
         if (first_v < 0 && obs_valid) first_v = i;
         n_chk++;
         if (obs_req !== 1'b1 || obs_addr !== 32'(4 * i))
            $display("FAIL stream_req[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, obs_req, obs_addr, 32'(4 * i));
         else n_pass++;
         if (i >= 2) begin
            n_chk++;
            if (obs_valid !== 1'b1 || obs_pc !== 32'(4 * (i - 2)) || obs_instr !== memf(32'(4 * (i - 2))))
               $display("FAIL stream_head[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                        i, obs_valid, obs_pc, obs_instr, 32'(4 * (i - 2)), memf(32'(4 * (i - 2))));
            else n_pass++;
         end
      end
      n_chk++;
      if (first_g < 0 || first_v - first_g != 2)
         $display("FAIL stream_latency: got grant@%0d valid@%0d expected distance 2", first_g, first_v);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int          grants = 0;
      logic [31:0] nxt = 32'h0;
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (obs_grant) grants++;
         if (i >= 2) begin
            n_chk++;
            if (obs_valid !== 1'b1 || obs_pc !== 32'h0)
               $display("FAIL bp_hold[%0d]: got v=%b pc=%h expected v=1 pc=00000000", i, obs_valid, obs_pc);
            else n_pass++;
         end
      end
      n_chk++; if (grants != DEPTH) $display("FAIL bp_grants: got %0d expected %0d", grants, DEPTH); else n_pass++;
      n_chk++; if (obs_req !== 1'b0) $display("FAIL bp_req_off: got %b expected 0", obs_req); else n_pass++;
      instr_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (obs_valid) begin
            n_chk++;
            if (obs_pc !== nxt || obs_instr !== memf(nxt))
               $display("FAIL bp_resume: got pc=%h instr=%h expected pc=%h instr=%h", obs_pc, obs_instr, nxt, memf(nxt));
            else n_pass++;
            nxt += 32'd4;
         end
      end
      n_chk++; if (nxt !== 32'd32) $display("FAIL bp_rate: got %0d pops expected 8", nxt / 4); else n_pass++;
   endtask

   task automatic test_gnt_stall();
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
      repeat (2) step();
      imem_gnt_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++;
         if (obs_addr !== 32'h8 || obs_req !== 1'b1)
            $display("FAIL stall_hold[%0d]: got addr=%h req=%b expected addr=00000008 req=1", i, obs_addr, obs_req);
         else n_pass++;
      end
      imem_gnt_i = 1'b1;
      step();
      step();
      n_chk++; if (obs_addr !== 32'hC) $display("FAIL stall_advance: got %h expected 0000000c", obs_addr); else n_pass++;
   endtask

   task automatic test_redirect();
      bit found = 1'b0;
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
      repeat (3) step();
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      step();
      n_chk++; if (obs_req !== 1'b0) $display("FAIL redir_req_off: got %b expected 0", obs_req); else n_pass++;
      redirect_i = 1'b0;
      step();
      n_chk++;
      if (obs_valid !== 1'b0 || obs_addr !== 32'h100 || obs_req !== 1'b1)
         $display("FAIL redir_flush: got v=%b addr=%h req=%b expected v=0 addr=00000100 req=1", obs_valid, obs_addr, obs_req);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         step();
         if (!found && obs_valid) begin
            found = 1'b1;
            n_chk++;
            if (obs_pc !== 32'h100 || obs_instr !== memf(32'h100))
               $display("FAIL redir_first: got pc=%h instr=%h expected pc=00000100 instr=%h", obs_pc, obs_instr, memf(32'h100));
            else n_pass++;
         end
      end
      if (!found) begin n_chk++; $display("FAIL redir_first: got no instruction in 6 cycles expected pc 00000100"); end
   endtask

   task automatic test_align();
      bit          found = 1'b0;
      logic [31:0] tgt;
      do_reset();
      imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
      repeat (2) step();
      redirect_i = 1'b1; redirect_pc_i = 32'h102;
      step();
      redirect_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      repeat (3) begin
         step();
         n_chk++;
         if (obs_fault !== 1'b1 || obs_req !== 1'b0 || obs_valid !== 1'b0)
            $display("FAIL align_fault: got fault=%b req=%b v=%b expected fault=1 req=0 v=0", obs_fault, obs_req, obs_valid);
         else n_pass++;
      end
      redirect_i = 1'b1; redirect_pc_i = 32'h200;
      step();
      redirect_i = 1'b0;
      tgt = 32'h200;
`else
      tgt = 32'h100;
`endif
      step();
      n_chk++;
      if (obs_fault !== 1'b0 || obs_addr !== tgt || obs_req !== 1'b1)
         $display("FAIL align_resume: got fault=%b addr=%h req=%b expected fault=0 addr=%h req=1", obs_fault, obs_addr, obs_req, tgt);
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         step();
         if (!found && obs_valid) begin
            found = 1'b1;
            n_chk++;
            if (obs_pc !== tgt) $display("FAIL align_first: got pc=%h expected %h", obs_pc, tgt);
            else n_pass++;
         end
      end
      if (!found) begin n_chk++; $display("FAIL align_first: got no instruction in 6 cycles expected pc %h", tgt); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         imem_gnt_i    = ($urandom_range(3) != 0);
         instr_ready_i = ($urandom_range(2) != 0);
         redirect_i    = ($urandom_range(11) == 0);
         redirect_pc_i = $urandom & 32'h0000_0FFC;
         if ($urandom_range(3) == 0) redirect_pc_i[1:0] = 2'($urandom_range(1, 3));
         step();
         n_chk++;
         if (obs_req !== exp_req || obs_addr !== exp_addr)
            $display("FAIL rnd_req[%0d]: got req=%b addr=%h expected req=%b addr=%h", i, obs_req, obs_addr, exp_req, exp_addr);
         else n_pass++;
         n_chk++;
         if (obs_valid !== exp_valid || obs_fault !== exp_fault)
            $display("FAIL rnd_state[%0d]: got v=%b fault=%b expected v=%b fault=%b", i, obs_valid, obs_fault, exp_valid, exp_fault);
         else n_pass++;
         if (exp_valid) begin
            n_chk++;
            if (obs_pc !== exp_pc || obs_instr !== exp_instr)
               $display("FAIL rnd_head[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", i, obs_pc, obs_instr, exp_pc, exp_instr);
            else n_pass++;
         end
      end
      redirect_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_gnt_stall();
      test_redirect();
      test_align();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before 1 ms");
      $fatal(1);
   end

endmodule
